// File: rtl/action_seq_pkg.sv
// Shared types and helpers for the action sequencer.
package action_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GAP   = 2'd1,
        PULSE = 2'd2
    } state_t;

    // Widest counter the width helper handles; callers truncate to their own width.
    localparam int unsigned EFF_W = 64;

    // Effective width: a programmed 0 behaves as 1.
    function automatic logic [EFF_W-1:0] eff_width(input logic [EFF_W-1:0] x);
        return (x == '0) ? EFF_W'(1) : x;
    endfunction

endpackage

// File: rtl/action_seq_next_ch.sv
// Next/first enabled channel search over a channel mask in either direction.
module action_seq_next_ch #(
    parameter int unsigned CH_NUM = 8,
    parameter int unsigned CH_W   = 3
) (
    input  logic [CH_NUM-1:0] mask,
    input  logic              rev,
    input  logic [CH_W-1:0]   cur,
    output logic [CH_W-1:0]   nxt_ch,
    output logic              last,
    output logic [CH_W-1:0]   first_ch
);

    // Scan so that the nearest qualifying channel is the final assignment.
    always_comb begin
        nxt_ch   = cur;
        last     = 1'b1;
        first_ch = '0;
        if (!rev) begin
            for (int i = int'(CH_NUM) - 1; i >= 0; i--) begin
                if (mask[i]) begin
                    first_ch = CH_W'(i);
                end
                if (mask[i] && (CH_W'(i) > cur)) begin
                    nxt_ch = CH_W'(i);
                    last   = 1'b0;
                end
            end
        end else begin
            for (int i = 0; i < int'(CH_NUM); i++) begin
                if (mask[i]) begin
                    first_ch = CH_W'(i);
                end
                if (mask[i] && (CH_W'(i) < cur)) begin
                    nxt_ch = CH_W'(i);
                    last   = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/action_sequencer.sv
// Multi-channel trigger sequencer: one pulse per enabled channel, gapped, repeatable.
module action_sequencer
    import action_seq_pkg::*;
#(
    parameter  int unsigned CH_NUM = 8,
    parameter  int unsigned CNT_W  = 32,
    parameter  int unsigned RPT_W  = 16,
    localparam int unsigned CH_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  step_wdth,
    input  logic [CNT_W-1:0]  pulse_wdth,
    input  logic [CH_NUM-1:0] chan_mask,
    input  logic              reverse,
    input  logic [RPT_W-1:0]  rpt_cnt,
    output logic              busy,
    output logic              done,
    output logic [CH_W-1:0]   cur_ch,
    output logic [CH_NUM-1:0] out
);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   s_q;
    logic [CNT_W-1:0]   p_q;
    logic [CH_NUM-1:0]  mask_q;
    logic               rev_q;
    logic [RPT_W-1:0]   rem_q;
    logic               cont_q;

    logic [CNT_W-1:0]   s_eff;
    logic [CNT_W-1:0]   p_eff;
    logic [CH_NUM-1:0]  sel_mask;
    logic               sel_rev;
    logic [CH_W-1:0]    nxt_ch;
    logic               last;
    logic [CH_W-1:0]    first_ch;

    // Live programming inputs only matter while idle; afterwards the latched copies rule.
    always_comb begin
        s_eff    = CNT_W'(eff_width(EFF_W'(step_wdth)));
        p_eff    = CNT_W'(eff_width(EFF_W'(pulse_wdth)));
        sel_mask = (state == IDLE) ? chan_mask : mask_q;
        sel_rev  = (state == IDLE) ? reverse   : rev_q;
    end

    action_seq_next_ch #(
        .CH_NUM (CH_NUM),
        .CH_W   (CH_W)
    ) u_next_ch (
        .mask     (sel_mask),
        .rev      (sel_rev),
        .cur      (cur_ch),
        .nxt_ch   (nxt_ch),
        .last     (last),
        .first_ch (first_ch)
    );

    // Sequencer FSM; cnt counts down the remaining cycles of the current GAP/PULSE.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state  <= IDLE;
            cnt    <= '0;
            s_q    <= '0;
            p_q    <= '0;
            mask_q <= '0;
            rev_q  <= 1'b0;
            rem_q  <= '0;
            cont_q <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            cur_ch <= '0;
            out    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        if (chan_mask != '0) begin
                            s_q    <= s_eff;
                            p_q    <= p_eff;
                            mask_q <= chan_mask;
                            rev_q  <= reverse;
                            rem_q  <= rpt_cnt;
                            cont_q <= (rpt_cnt == '0);
                            cnt    <= s_eff - CNT_W'(1);
                            cur_ch <= first_ch;
                            busy   <= 1'b1;
                            state  <= GAP;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        out   <= '0;
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        cnt   <= p_q - CNT_W'(1);
                        out   <= CH_NUM'(1) << cur_ch;
                        state <= PULSE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                PULSE: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        out   <= '0;
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        out <= '0;
                        if (!last) begin
                            cur_ch <= nxt_ch;
                            cnt    <= s_q - CNT_W'(1);
                            state  <= GAP;
                        end else if (cont_q || (rem_q > RPT_W'(1))) begin
                            if (!cont_q) begin
                                rem_q <= rem_q - RPT_W'(1);
                            end
                            cur_ch <= first_ch;
                            cnt    <= s_q - CNT_W'(1);
                            state  <= GAP;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    out   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_action_sequencer.sv
// Directed self-checking bench for action_sequencer.
module tb_action_sequencer;

    localparam int unsigned CH_NUM = 8;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned RPT_W  = 16;
    localparam int unsigned CH_W   = 3;

    logic              clk = 1'b0;
    logic              nrst;
    logic              start;
    logic              abort;
    logic [CNT_W-1:0]  step_wdth;
    logic [CNT_W-1:0]  pulse_wdth;
    logic [CH_NUM-1:0] chan_mask;
    logic              reverse;
    logic [RPT_W-1:0]  rpt_cnt;
    logic              busy;
    logic              done;
    logic [CH_W-1:0]   cur_ch;
    logic [CH_NUM-1:0] out_v;

    int total  = 0;
    int passed = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    action_sequencer #(
        .CH_NUM (CH_NUM),
        .CNT_W  (CNT_W),
        .RPT_W  (RPT_W)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .start      (start),
        .abort      (abort),
        .step_wdth  (step_wdth),
        .pulse_wdth (pulse_wdth),
        .chan_mask  (chan_mask),
        .reverse    (reverse),
        .rpt_cnt    (rpt_cnt),
        .busy       (busy),
        .done       (done),
        .cur_ch     (cur_ch),
        .out        (out_v)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock; cyc N means "just after edge N".
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    // Program and start; returns at cycle 0 (start sampled at edge 0).
    task automatic go(input logic [CNT_W-1:0] s, input logic [CNT_W-1:0] p,
                      input logic [CH_NUM-1:0] m, input logic r, input logic [RPT_W-1:0] n);
        step_wdth  = s;
        pulse_wdth = p;
        chan_mask  = m;
        reverse    = r;
        rpt_cnt    = n;
        start      = 1'b1;
        cyc        = -1;
        tick();
        start      = 1'b0;
    endtask

    initial begin
        logic [CH_NUM-1:0] exp_out;
        nrst = 1'b0; start = 1'b0; abort = 1'b0;
        step_wdth = '0; pulse_wdth = '0; chan_mask = '0; reverse = 1'b0; rpt_cnt = '0;
        tick(); tick();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_cur",  64'(cur_ch), 64'(0));
        chk("rst_out",  64'(out_v), 64'(0));
        nrst = 1'b1;
        tick();

        // Ascending full mask, S=3 P=2: channel c pulses in cycles 5c+3..5c+4, done at 40.
        go(32'd3, 32'd2, 8'hFF, 1'b0, 16'd1);
        for (int c = 0; c <= 41; c++) begin
            run_to(c);
            exp_out = (c < 40 && (c % 5) >= 3) ? (8'h01 << (c / 5)) : 8'h00;
            chk($sformatf("asc_out_c%0d", c),  64'(out_v), 64'(exp_out));
            chk($sformatf("asc_busy_c%0d", c), 64'(busy), 64'(c < 40));
            chk($sformatf("asc_done_c%0d", c), 64'(done), 64'(c == 40));
            if (c == 38) chk("asc_cur_c38", 64'(cur_ch), 64'(7));
        end

        // Masked descending, S=1 P=1 (inputs changed while running must not matter).
        go(32'd1, 32'd1, 8'b1010_0100, 1'b1, 16'd1);
        chan_mask = 8'hFF; step_wdth = 32'd5; reverse = 1'b0; rpt_cnt = 16'd4;
        for (int c = 0; c <= 6; c++) begin
            run_to(c);
            case (c)
                1: exp_out = 8'h80;
                3: exp_out = 8'h20;
                5: exp_out = 8'h04;
                default: exp_out = 8'h00;
            endcase
            chk($sformatf("desc_out_c%0d", c), 64'(out_v), 64'(exp_out));
            chk($sformatf("desc_done_c%0d", c), 64'(done), 64'(c == 6));
            if (c < 6) chk($sformatf("desc_cur_c%0d", c), 64'(cur_ch), 64'(c < 2 ? 7 : (c < 4 ? 5 : 2)));
        end
        chk("desc_busy_end", 64'(busy), 64'(0));

        // Three passes over channels 0,1: pulses on odd cycles, order 0,1,0,1,0,1.
        go(32'd1, 32'd1, 8'h03, 1'b0, 16'd3);
        for (int c = 0; c <= 14; c++) begin
            run_to(c);
            exp_out = (c < 12 && (c % 2) == 1) ? (8'h01 << (((c - 1) / 2) % 2)) : 8'h00;
            chk($sformatf("rpt_out_c%0d", c),  64'(out_v), 64'(exp_out));
            chk($sformatf("rpt_done_c%0d", c), 64'(done), 64'(c == 12));
            chk($sformatf("rpt_busy_c%0d", c), 64'(busy), 64'(c < 12));
        end

        // Continuous mode, S=2 P=3 on channel 0: period 5, then abort mid-pulse.
        go(32'd2, 32'd3, 8'h01, 1'b0, 16'd0);
        run_to(2);  chk("cont_out_c2",  64'(out_v), 64'h01);
        run_to(5);  chk("cont_out_c5",  64'(out_v), 64'h00);
        run_to(7);  chk("cont_out_c7",  64'(out_v), 64'h01);
        run_to(12); chk("cont_out_c12", 64'(out_v), 64'h01);
        run_to(13); chk("cont_busy_c13", 64'(busy), 64'(1));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_out",  64'(out_v), 64'h00);
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        tick();
        chk("abort_done_after", 64'(done), 64'(0));
        go(32'd1, 32'd1, 8'h01, 1'b0, 16'd1);
        run_to(1); chk("restart_out",  64'(out_v), 64'h01);
        run_to(2); chk("restart_done", 64'(done), 64'(1));

        // Abort wins over start in idle.
        start = 1'b1; abort = 1'b1; chan_mask = 8'h01;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("abort_start_busy", 64'(busy), 64'(0));
        chk("abort_start_done", 64'(done), 64'(0));

        // Zero widths behave as 1.
        go(32'd0, 32'd0, 8'h02, 1'b0, 16'd1);
        chk("zero_busy_c0", 64'(busy), 64'(1));
        run_to(1); chk("zero_out_c1",  64'(out_v), 64'h02);
        run_to(2); chk("zero_done_c2", 64'(done), 64'(1));
        chk("zero_out_c2", 64'(out_v), 64'h00);

        // Empty mask: done strobe, never busy.
        go(32'd1, 32'd1, 8'h00, 1'b0, 16'd1);
        chk("empty_busy_c0", 64'(busy), 64'(0));
        chk("empty_done_c0", 64'(done), 64'(1));
        run_to(1);
        chk("empty_done_c1", 64'(done), 64'(0));
        chk("empty_busy_c1", 64'(busy), 64'(0));

        // Reset mid-GAP.
        go(32'd5, 32'd1, 8'h08, 1'b0, 16'd1);
        run_to(2);
        chk("rgap_busy_pre", 64'(busy), 64'(1));
        chk("rgap_cur_pre",  64'(cur_ch), 64'(3));
        nrst = 1'b0;
        tick();
        chk("rgap_busy", 64'(busy), 64'(0));
        chk("rgap_cur",  64'(cur_ch), 64'(0));
        chk("rgap_out",  64'(out_v), 64'h00);
        chk("rgap_done", 64'(done), 64'(0));
        nrst = 1'b1;
        tick();

        // Reset mid-PULSE.
        go(32'd1, 32'd3, 8'h10, 1'b0, 16'd1);
        run_to(2); chk("rpul_out_pre", 64'(out_v), 64'h10);
        nrst = 1'b0;
        tick();
        chk("rpul_out",  64'(out_v), 64'h00);
        chk("rpul_busy", 64'(busy), 64'(0));
        nrst = 1'b1;
        tick();

        // Start re-asserted while busy is ignored; held start restarts after done.
        go(32'd2, 32'd2, 8'h03, 1'b0, 16'd1);
        run_to(2); chk("ign_out_c2", 64'(out_v), 64'h01);
        run_to(3);
        start = 1'b1;
        run_to(4); chk("ign_out_c4", 64'(out_v), 64'h00);
        run_to(6); chk("ign_out_c6", 64'(out_v), 64'h02);
        run_to(7); chk("ign_out_c7", 64'(out_v), 64'h02);
        run_to(8);
        chk("ign_done_c8", 64'(done), 64'(1));
        chk("ign_busy_c8", 64'(busy), 64'(0));
        run_to(9);
        chk("hold_busy_c9", 64'(busy), 64'(1));
        chk("hold_done_c9", 64'(done), 64'(0));
        chk("hold_cur_c9",  64'(cur_ch), 64'(0));
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("hold_abort_busy", 64'(busy), 64'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/action_sequencer.md
# action_sequencer

Parametrised multi-channel trigger sequencer: after `start` it fires one pulse per enabled channel, in strict channel order, separated by a programmable gap. It can repeat the sequence a given number of passes or until aborted. It is the general-purpose successor to the team's fixed one-shot burst generator and adds:

- channel masking
- programmable pulse width
- reverse order
- repeat and continuous modes
- abort
- a `done` strobe

## Interface
- `CH_NUM`, 8: number of output channels, ≥2.
- `CNT_W`, 32: width of the gap and pulse-width counters.
- `RPT_W`, 16: width of the repeat count.
- `CH_W`, $clog2(CH_NUM): derived localparam, not overridable.

- `clk` in 1: clock, all logic on rising edge.
- `nrst` in 1: reset, synchronous, active-low.
- `start` in 1: level-sampled start request, honoured only while idle.
- `abort` in 1: stop the running sequence.
- `step_wdth` in CNT_W: gap cycles before each pulse; 0 is treated as 1.
- `pulse_wdth` in CNT_W: high cycles of each pulse; 0 is treated as 1.
- `chan_mask` in CH_NUM: 1 = channel participates.
- `reverse` in 1: 0 = ascending order, 1 = descending order.
- `rpt_cnt` in RPT_W: number of passes; 0 = continuous until abort.
- `busy` out 1: sequence running.
- `done` out 1: one-cycle strobe on normal completion.
- `cur_ch` out CH_W: index of the channel being timed.
- `out` out CH_NUM: trigger outputs; at most one bit is high at any time.

## Operation
- **States:** IDLE, GAP, PULSE. A register `done` is set for exactly one cycle.
- **IDLE.** When `start`=1, `abort`=0 and `chan_mask`≠0:
  - Latch S=max(`step_wdth`,1), P=max(`pulse_wdth`,1), `chan_mask`, `reverse` and `rpt_cnt`.
  - Set `cur_ch` to the first enabled channel: lowest index if ascending, highest if descending.
  - Enter GAP and set `busy`=1.
- **Empty mask.** `start` with `chan_mask`=0 produces no `busy`; `done` pulses on the next cycle.
- **GAP.** Count S cycles, then enter PULSE.
- **PULSE.** `out[cur_ch]`=1 for P cycles. On the last PULSE cycle:
  - If another enabled channel exists in the current direction: `cur_ch` moves to it (masked channels are skipped, with no gap spent on them), go to GAP.
  - Else, at end of pass: decrement the remaining-pass counter. If passes remain, or `rpt_cnt` was 0, wrap `cur_ch` to the first enabled channel and go to GAP.
  - Otherwise go to IDLE, clear `busy`, set `done`=1 for one cycle.
- **Input changes while running.** Changes on `step_wdth`, `pulse_wdth`, `chan_mask`, `reverse` or `rpt_cnt` while `busy` have no effect until the next start.
- **`start` while `busy`** is ignored. Holding `start` high continuously restarts the sequence on the cycle after `done`.
- **`abort` while `busy`:** next edge → IDLE, `out`=0, `busy`=0, no `done`. `abort` in IDLE wins over a simultaneous `start`.
- **`nrst`=0:** next edge → IDLE, with latched counters and all outputs cleared. This applies from any state, including mid-pulse.
- **Arithmetic.** Counters are CNT_W bits, unsigned and never wrap: S and P up to 2^CNT_W−1 are legal. The pass counter is RPT_W bits.

## Timing
- **Reset values:** `busy`=0, `done`=0, `cur_ch`=0, `out`=0.
- **Start latency.** `start` is sampled at edge k, and `busy`=1 from edge k. `out[first]` rises at edge k+S and stays high for P cycles. The next pulse rises S cycles after the previous one falls.
- **Duration.** Total `busy` length = N·(S+P)·R cycles, where N is the number of enabled channels and R=`rpt_cnt`.
- **`done` alignment.** `done` rises on the same edge that the last pulse falls and `busy` falls.
- **Glitch-free outputs.** Outputs are registered, so there are no combinational paths from inputs to `out`, `busy` or `done`.

## Structure
- **Package `action_seq_pkg`:**
  - state enum (IDLE, GAP, PULSE)
  - function returning the effective width, max(x,1)
- **Sub-module `action_seq_next_ch`:**
  - combinational next-set-bit search over the latched mask
  - inputs: current index, direction
  - outputs: next index, last-in-pass flag, first enabled index
  - instantiated once

## Test plan
- **Basic ascending run.** CH_NUM=8, mask=8'hFF, S=3, P=2, `rpt_cnt`=1, `start` at cycle 0 → `out[0]` high in cycles 3–4, `out[1]` high in cycles 8–9, …, `out[7]` high in cycles 38–39; `done` at 40; `busy` high for cycles 0–39.
- **Masked, descending.** mask=8'b1010_0100, `reverse`=1, S=1, P=1 → pulses on channels 7, 5, 2 only, 2 cycles apart; `cur_ch` never takes a masked index.
- **Repeat.** `rpt_cnt`=3, mask=8'h03 → 6 pulses, order 0,1,0,1,0,1, then a single `done`.
- **Continuous mode and abort.** `rpt_cnt`=0, then `abort` mid-PULSE → `out`=0 and `busy`=0 on the next edge; no `done`; a new `start` works normally.
- **Zero widths and empty mask.** S=0, P=0 behave as 1. `start` with mask=0 → `done` one cycle later, `busy` stays 0.
- **Reset and ignored start.** `nrst` low mid-GAP → all outputs 0 on the next edge. `start` re-pulsed while `busy` → no effect on timing.
